// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and forward-select codes for hazard_ctrl.
`default_nettype none

package hazard_pkg;

  localparam int REG_W = 4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_RW  = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fwd_sel.sv
// fwd_sel: priority comparator choosing one execute operand's bypass source.
`default_nettype none

module fwd_sel
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] i_rs,
  input  logic [REG_W-1:0] i_rd_m,
  input  logic [REG_W-1:0] i_rd_w,
  input  logic             i_wb_m,
  input  logic             i_wb_w,
  output logic [1:0]       o_fwd
);

  // The memory stage holds the younger result, so it wins over writeback.
  always_comb begin
    o_fwd = FWD_REG;
    if (i_wb_m && (i_rd_m == i_rs)) begin
      o_fwd = FWD_M;
    end else if (i_wb_w && (i_rd_w == i_rs)) begin
      o_fwd = FWD_RW;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use/branch hazards and multicycle-ALU stall FSM.
// Define HAZARD_PERF_EN to add saturating stall_cnt/flush_cnt counters.
`default_nettype none

module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MC_MAX_CYCLES = 40,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] RS1_D,
  input  logic [REG_W-1:0] RS2_D,
  input  logic [REG_W-1:0] RS1_E,
  input  logic [REG_W-1:0] RS2_E,
  input  logic [REG_W-1:0] RD_E,
  input  logic [REG_W-1:0] RD_M,
  input  logic [REG_W-1:0] RD_W,
  input  logic             isWb_E,
  input  logic             isWb_M,
  input  logic             isWb_W,
  input  logic             isLd_E,
  input  logic             isbranchtaken_E,
  input  logic             mc_start_E,
  input  logic             mc_done,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             flush_D,
  output logic             flush_E,
  output logic             mc_go,
  output logic             mc_busy,
  output logic             mc_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int MC_CNT_W = $clog2(MC_MAX_CYCLES + 1);
  localparam logic [MC_CNT_W-1:0] MC_LIMIT = MC_CNT_W'(MC_MAX_CYCLES);

  state_t              r_state;
  state_t              w_next;
  logic [MC_CNT_W-1:0] r_mc_cnt;
  logic [MC_CNT_W-1:0] w_mc_cnt_nxt;
  logic                r_mc_err;
  logic                w_err_set;
  logic                w_load_use;
  logic                w_stall_f;
  logic                w_stall_d;
  logic                w_stall_e;
  logic                w_flush_d;
  logic                w_flush_e;
  logic                w_go;

  fwd_sel u_fwd_a (
    .i_rs   (RS1_E),
    .i_rd_m (RD_M),
    .i_rd_w (RD_W),
    .i_wb_m (isWb_M),
    .i_wb_w (isWb_W),
    .o_fwd  (forwardA_E)
  );

  fwd_sel u_fwd_b (
    .i_rs   (RS2_E),
    .i_rd_m (RD_M),
    .i_rd_w (RD_W),
    .i_wb_m (isWb_M),
    .i_wb_w (isWb_W),
    .o_fwd  (forwardB_E)
  );

  assign w_load_use = isLd_E && isWb_E && ((RD_E == RS1_D) || (RD_E == RS2_D));

  always_comb begin
    w_next       = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    w_err_set    = 1'b0;
    w_stall_f    = 1'b0;
    w_stall_d    = 1'b0;
    w_stall_e    = 1'b0;
    w_flush_d    = 1'b0;
    w_flush_e    = 1'b0;
    w_go         = 1'b0;
    case (r_state)
      RUN: begin
        if (isbranchtaken_E) begin
          w_flush_d = 1'b1;
          w_flush_e = 1'b1;
        end else if (mc_start_E) begin
          w_go         = 1'b1;
          w_stall_f    = 1'b1;
          w_stall_d    = 1'b1;
          w_stall_e    = 1'b1;
          w_mc_cnt_nxt = '0;
          w_next       = MC_WAIT;
        end else if (w_load_use) begin
          w_stall_f = 1'b1;
          w_stall_d = 1'b1;
          w_flush_e = 1'b1;
        end
      end
      MC_WAIT: begin
        // Releasing the stalls in the done cycle lets E/M capture the result.
        if (mc_done) begin
          w_next = RUN;
        end else if (r_mc_cnt == MC_LIMIT) begin
          w_err_set = 1'b1;
          w_flush_e = 1'b1;
          w_next    = RUN;
        end else begin
          w_stall_f    = 1'b1;
          w_stall_d    = 1'b1;
          w_stall_e    = 1'b1;
          w_mc_cnt_nxt = r_mc_cnt + MC_CNT_W'(1);
        end
      end
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_mc_cnt <= '0;
      r_mc_err <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_mc_cnt <= w_mc_cnt_nxt;
      if (w_err_set) begin
        r_mc_err <= 1'b1;
      end
    end
  end

  assign stall_F = ~rst & w_stall_f;
  assign stall_D = ~rst & w_stall_d;
  assign stall_E = ~rst & w_stall_e;
  assign flush_D = ~rst & w_flush_d;
  assign flush_E = ~rst & w_flush_e;
  assign mc_go   = ~rst & w_go;
  assign mc_busy = ~rst & (r_state == MC_WAIT);
  assign mc_err  = r_mc_err;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((stall_F | stall_D | stall_E) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if ((flush_D | flush_E) && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  // CNT_W only sizes the optional counters; keep it referenced in this build.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scoreboard bench for hazard_ctrl.
`default_nettype none

module tb_hazard_ctrl;

  localparam int MAXC = 8;
  localparam int CW   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic       isWb_E, isWb_M, isWb_W, isLd_E, isbranchtaken_E, mc_start_E, mc_done;
  logic [1:0] forwardA_E, forwardB_E;
  logic       stall_F, stall_D, stall_E, flush_D, flush_E, mc_go, mc_busy, mc_err;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] stall_cnt, flush_cnt;
  int exp_stall = 0;
  int exp_flush = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MC_MAX_CYCLES(MAXC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
    .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
    .isWb_E(isWb_E), .isWb_M(isWb_M), .isWb_W(isWb_W), .isLd_E(isLd_E),
    .isbranchtaken_E(isbranchtaken_E), .mc_start_E(mc_start_E), .mc_done(mc_done),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E),
    .flush_D(flush_D), .flush_E(flush_E),
    .mc_go(mc_go), .mc_busy(mc_busy), .mc_err(mc_err)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ctl bits: {stall_F, stall_D, stall_E, flush_D, flush_E, mc_go, mc_busy, mc_err}
  function automatic logic [11:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic [7:0] ctl);
    return {fa, fb, ctl};
  endfunction

  task automatic cyc(input string tag, input logic [11:0] exp);
    logic [11:0] got;
    logic [11:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    got = {forwardA_E, forwardB_E, stall_F, stall_D, stall_E, flush_D, flush_E,
           mc_go, mc_busy, mc_err};
    e = exp_q.pop_front();
    check_val(tag, 32'(got), 32'(e));
`ifdef HAZARD_PERF_EN
    if (rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end
    check_val({tag, "/scnt"}, 32'(stall_cnt), 32'(exp_stall));
    check_val({tag, "/fcnt"}, 32'(flush_cnt), 32'(exp_flush));
    if (!rst) begin
      if ((|e[7:5]) && exp_stall < (1 << CW) - 1) exp_stall++;
      if ((|e[4:3]) && exp_flush < (1 << CW) - 1) exp_flush++;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RS1_D = 4'd1; RS2_D = 4'd2; RS1_E = 4'd1; RS2_E = 4'd2;
    RD_E = 4'd0; RD_M = 4'd0; RD_W = 4'd0;
    isWb_E = 1'b0; isWb_M = 1'b0; isWb_W = 1'b0; isLd_E = 1'b0;
    isbranchtaken_E = 1'b0; mc_start_E = 1'b0; mc_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    // Every hazard source active while reset is held: outputs must stay low.
    isbranchtaken_E = 1'b1; mc_start_E = 1'b1;
    isLd_E = 1'b1; isWb_E = 1'b1; RD_E = 4'd1;
    cyc("rst_hold0", mk(2'b00, 2'b00, 8'b000_00_000));
    cyc("rst_hold1", mk(2'b00, 2'b00, 8'b000_00_000));
    idle();
    rst = 1'b0;
    cyc("post_rst", mk(2'b00, 2'b00, 8'b000_00_000));

    // Forwarding priority
    RS1_E = 4'd3; RD_M = 4'd3; isWb_M = 1'b1; RD_W = 4'd3; isWb_W = 1'b1;
    cyc("fwdA_m", mk(2'b10, 2'b00, 8'b0));
    isWb_M = 1'b0;
    cyc("fwdA_w", mk(2'b01, 2'b00, 8'b0));
    isWb_W = 1'b0;
    cyc("fwdA_reg", mk(2'b00, 2'b00, 8'b0));
    RS1_E = 4'd0; RS2_E = 4'd0; RD_M = 4'd0; isWb_M = 1'b1;
    cyc("fwd_r0", mk(2'b10, 2'b10, 8'b0));
    RS2_E = 4'd7; RD_W = 4'd7; isWb_W = 1'b1;
    cyc("fwd_mix", mk(2'b10, 2'b01, 8'b0));
    idle();

    // Load-use, branch and their combination
    isLd_E = 1'b1; isWb_E = 1'b1; RD_E = 4'd5; RS2_D = 4'd5;
    cyc("ldu_rs2", mk(2'b00, 2'b00, 8'b110_01_000));
    idle();
    cyc("ldu_gone", mk(2'b00, 2'b00, 8'b0));
    isLd_E = 1'b1; isWb_E = 1'b1; RD_E = 4'd1;
    cyc("ldu_rs1", mk(2'b00, 2'b00, 8'b110_01_000));
    isWb_E = 1'b0;
    cyc("ldu_nowb", mk(2'b00, 2'b00, 8'b0));
    isWb_E = 1'b1; RD_E = 4'd5; RS2_D = 4'd5; isbranchtaken_E = 1'b1;
    cyc("br_ldu", mk(2'b00, 2'b00, 8'b000_11_000));
    idle();
    isbranchtaken_E = 1'b1;
    cyc("br_only", mk(2'b00, 2'b00, 8'b000_11_000));
    idle();
    mc_done = 1'b1;
    cyc("done_in_run", mk(2'b00, 2'b00, 8'b0));
    idle();

    // Multicycle op completing six cycles after start
    mc_start_E = 1'b1;
    cyc("mc_start", mk(2'b00, 2'b00, 8'b111_00_100));
    mc_start_E = 1'b0;
    cyc("mc_w1", mk(2'b00, 2'b00, 8'b111_00_010));
    isbranchtaken_E = 1'b1; isLd_E = 1'b1; isWb_E = 1'b1; RD_E = 4'd1;
    cyc("mc_w2_mask", mk(2'b00, 2'b00, 8'b111_00_010));
    idle();
    RS1_E = 4'd3; RD_M = 4'd3; isWb_M = 1'b1;
    cyc("mc_w3_fwd", mk(2'b10, 2'b00, 8'b111_00_010));
    idle();
    cyc("mc_w4", mk(2'b00, 2'b00, 8'b111_00_010));
    cyc("mc_w5", mk(2'b00, 2'b00, 8'b111_00_010));
    mc_done = 1'b1;
    cyc("mc_done", mk(2'b00, 2'b00, 8'b000_00_010));
    idle();
    cyc("mc_back_run", mk(2'b00, 2'b00, 8'b0));

    // Branch beats a multicycle start
    isbranchtaken_E = 1'b1; mc_start_E = 1'b1;
    cyc("br_mcstart", mk(2'b00, 2'b00, 8'b000_11_000));
    idle();
    cyc("br_mc_run", mk(2'b00, 2'b00, 8'b0));

    // Timeout: MAXC stalled wait cycles, then one flush cycle
    mc_start_E = 1'b1;
    cyc("to_start", mk(2'b00, 2'b00, 8'b111_00_100));
    mc_start_E = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      cyc($sformatf("to_wait%0d", i), mk(2'b00, 2'b00, 8'b111_00_010));
    end
    cyc("to_flush", mk(2'b00, 2'b00, 8'b000_01_010));
    cyc("to_err", mk(2'b00, 2'b00, 8'b000_00_001));
    cyc("to_err_hold", mk(2'b00, 2'b00, 8'b000_00_001));
    mc_start_E = 1'b1;
    cyc("err_start", mk(2'b00, 2'b00, 8'b111_00_101));
    mc_start_E = 1'b0; mc_done = 1'b1;
    cyc("err_done", mk(2'b00, 2'b00, 8'b000_00_011));
    idle();
    cyc("err_sticky", mk(2'b00, 2'b00, 8'b000_00_001));

    // Reset in the third wait cycle abandons the op and clears mc_err
    mc_start_E = 1'b1;
    cyc("rw_start", mk(2'b00, 2'b00, 8'b111_00_101));
    mc_start_E = 1'b0;
    cyc("rw_w1", mk(2'b00, 2'b00, 8'b111_00_011));
    cyc("rw_w2", mk(2'b00, 2'b00, 8'b111_00_011));
    rst = 1'b1;
    cyc("rw_rst", mk(2'b00, 2'b00, 8'b0));
    rst = 1'b0;
    mc_done = 1'b1;
    cyc("rw_late_done", mk(2'b00, 2'b00, 8'b0));
    idle();
    cyc("rw_idle", mk(2'b00, 2'b00, 8'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
